// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder: slice width and FSM state encoding.
package adder_pkg;

    localparam int NIB_W = 4;

    // 2'd3 is unused; the top-level FSM treats it as IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_add_co.sv
// Combinational 4-bit adder slice with carry in/out; one instance is reused for every nibble.
module nibble_add_co
    import adder_pkg::*;
(
    input  logic [NIB_W-1:0] x,
    input  logic [NIB_W-1:0] y,
    input  logic             ci,
    output logic [NIB_W-1:0] s,
    output logic             co
);

    logic [NIB_W:0] w_full;

    assign w_full = {1'b0, x} + {1'b0, y} + {{NIB_W{1'b0}}, ci};
    assign s      = w_full[NIB_W-1:0];
    assign co     = w_full[NIB_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that walks the operands one nibble per clock, LSB first, through a
// single nibble_add_co slice, with valid/ready handshakes on both sides.
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NNIB  = WIDTH / NIB_W;
    localparam int IDX_W = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NNIB - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [WIDTH-1:0]       r_a_sh;
    logic [WIDTH-1:0]       r_b_sh;
    logic [WIDTH-1:0]       r_sum_sh;
    logic [WIDTH-1:0]       r_sum;
    logic                   r_carry;
    logic                   r_cout;
    logic                   r_out_valid;
    logic [IDX_W-1:0]       r_idx;
    logic [NIB_W-1:0]       w_nib_s;
    logic                   w_nib_co;
    logic [WIDTH+NIB_W-1:0] w_sum_cat;
    logic                   w_in_ready;
    logic                   w_accept;

    nibble_add_co u_nib (
        .x  (r_a_sh[NIB_W-1:0]),
        .y  (r_b_sh[NIB_W-1:0]),
        .ci (r_carry),
        .s  (w_nib_s),
        .co (w_nib_co)
    );

    // Concatenate-then-slice keeps the shift legal when WIDTH == NIB_W.
    assign w_sum_cat = {w_nib_s, r_sum_sh};
    assign w_accept  = w_in_ready & in_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            S_RUN: begin
                if (r_idx == LAST_IDX) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (r_out_valid && out_ready) w_state_nxt = S_IDLE;
            end
            default: begin
                w_in_ready = 1'b1;
                if (in_valid) w_state_nxt = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_sum_sh    <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a_sh  <= op_a;
                r_b_sh  <= op_b;
                r_carry <= cin;
                r_idx   <= '0;
            end else if (r_state == S_RUN) begin
                r_a_sh   <= r_a_sh >> NIB_W;
                r_b_sh   <= r_b_sh >> NIB_W;
                r_sum_sh <= w_sum_cat[WIDTH+NIB_W-1:NIB_W];
                r_carry  <= w_nib_co;
                if (r_idx != LAST_IDX) r_idx <= r_idx + 1'b1;
            end

            // Result is copied into a dedicated output register on the first DONE cycle,
            // so out_valid rises one edge after the final nibble step.
            if (r_state == S_DONE) begin
                if (!r_out_valid) begin
                    r_out_valid <= 1'b1;
                    r_sum       <= r_sum_sh;
                    r_cout      <= r_carry;
                end else if (out_ready) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: WIDTH=16 and WIDTH=4 instances checked
// against plain-arithmetic sums.
module tb_nibble_serial_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        iv16, ir16, c16, ov16, or16, co16;
    logic [15:0] a16, b16, s16;
    logic        iv4, ir4, c4, ov4, or4, co4;
    logic [3:0]  a4, b4, s4;

    int checks   = 0;
    int failures = 0;

    nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .op_a(a16), .op_b(b16),
        .cin(c16), .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .op_a(a4), .op_b(b4),
        .cin(c4), .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic [15:0] s;
        logic        co;
        int          hold;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] model16(input logic [15:0] a, input logic [15:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {16'd0, c};
    endfunction

    function automatic logic [4:0] model4(input logic [3:0] a, input logic [3:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {4'd0, c};
    endfunction

    // Starts and ends on a negedge; returns right after the result handshake.
    task automatic xact16(input logic [15:0] a, input logic [15:0] b, input logic c,
                          input int hold, input logic [15:0] es, input logic eco, input string tag);
        int n;
        n = 0;
        while (!ir16 && n < 30) begin @(negedge clk); n++; end
        check({tag, " in_ready"}, ir16, 1);
        iv16 = 1'b1; a16 = a; b16 = b; c16 = c; or16 = 1'b0;
        @(negedge clk);
        iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
        n = 0;
        while (!ov16 && n < 30) begin @(negedge clk); n++; end
        check({tag, " latency"}, n, 5);
        check({tag, " sum"}, s16, es);
        check({tag, " cout"}, co16, eco);
        for (int i = 0; i < hold; i++) begin
            iv16 = 1'b1;
            @(negedge clk);
            check({tag, " hold sum"}, s16, es);
            check({tag, " hold cout"}, co16, eco);
            check({tag, " hold out_valid"}, ov16, 1);
            check({tag, " hold in_ready"}, ir16, 0);
        end
        iv16 = 1'b0; or16 = 1'b1;
        @(negedge clk);
        check({tag, " post out_valid"}, ov16, 0);
        check({tag, " post in_ready"}, ir16, 1);
        or16 = 1'b0;
    endtask

    task automatic xact4(input logic [3:0] a, input logic [3:0] b, input logic c,
                         input logic [3:0] es, input logic eco, input string tag);
        int n;
        n = 0;
        while (!ir4 && n < 20) begin @(negedge clk); n++; end
        check({tag, " in_ready"}, ir4, 1);
        iv4 = 1'b1; a4 = a; b4 = b; c4 = c; or4 = 1'b1;
        @(negedge clk);
        iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
        n = 0;
        while (!ov4 && n < 20) begin @(negedge clk); n++; end
        check({tag, " latency"}, n, 2);
        check({tag, " sum"}, s4, es);
        check({tag, " cout"}, co4, eco);
        @(negedge clk);
        check({tag, " post out_valid"}, ov4, 0);
        or4 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16:0]  exp17;
        logic [4:0]   exp5;
        logic [15:0]  ra, rb;
        logic         rc;
        logic [3:0]   qa, qb;
        logic [16:0]  expq[$];
        int           acc, got, cyc, bad;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 3};
        vecs[2] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 0};
        vecs[3] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1};

        rst = 1'b1;
        iv16 = 0; a16 = '0; b16 = '0; c16 = 0; or16 = 0;
        iv4 = 0; a4 = '0; b4 = '0; c4 = 0; or4 = 0;
        @(negedge clk);
        check("reset in_ready", ir16, 1);
        check("reset out_valid", ov16, 0);
        check("reset sum", s16, 0);
        check("reset cout", co16, 0);
        check("reset w4 in_ready", ir4, 1);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++)
            xact16(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].hold, vecs[i].s, vecs[i].co,
                   $sformatf("vec%0d", i));

        // Asynchronous reset two cycles into RUN discards the transaction.
        iv16 = 1'b1; a16 = 16'h1234; b16 = 16'h1111; c16 = 1'b0;
        @(negedge clk);
        iv16 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst in_ready", ir16, 1);
        check("async rst out_valid", ov16, 0);
        check("async rst sum", s16, 0);
        check("async rst cout", co16, 0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ov16) bad++;
        end
        check("post rst no out_valid", bad, 0);
        xact16(16'h00AA, 16'h0055, 1'b0, 0, 16'h00FF, 1'b0, "after rst");

        for (int i = 0; i < 25; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            exp17 = model16(ra, rb, rc);
            xact16(ra, rb, rc, int'($urandom_range(0, 2)), exp17[15:0], exp17[16],
                   $sformatf("rand%0d", i));
        end

        // Back-to-back with in_valid held high and out_ready high.
        acc = 0; got = 0; cyc = 0;
        or16 = 1'b1; iv16 = 1'b1;
        a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
        while ((acc < 6 || got < acc) && cyc < 300) begin
            if (acc >= 6) iv16 = 1'b0;
            check("b2b exclusive", {31'd0, ov16 & ir16}, 0);
            if (ov16) begin
                if (expq.size() == 0) begin
                    check("b2b unexpected result", 1, 0);
                end else begin
                    check($sformatf("b2b result%0d", got), {15'd0, co16, s16}, {15'd0, expq.pop_front()});
                end
                got++;
            end
            if (ir16 && iv16) begin
                expq.push_back(model16(a16, b16, c16));
                acc++;
            end else begin
                a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        check("b2b accepted", acc, 6);
        check("b2b delivered", got, 6);
        check("b2b queue empty", expq.size(), 0);
        iv16 = 1'b0; or16 = 1'b0;
        @(negedge clk);

        xact4(4'hF, 4'h1, 1'b0, 4'h0, 1'b1, "w4 F+1");
        xact4(4'h7, 4'h8, 1'b1, 4'h0, 1'b1, "w4 7+8+1");
        for (int i = 0; i < 12; i++) begin
            qa = 4'($urandom); qb = 4'($urandom); rc = 1'($urandom);
            exp5 = model4(qa, qb, rc);
            xact4(qa, qb, rc, exp5[3:0], exp5[4], $sformatf("w4 rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
